// File: rtl/mem_master_if.sv
// mem_master_if: bundles the CPU-side request/response signals and the
// word-memory transaction signals seen by mem_master.
// master modport = mem_master's view; slave modport = environment's view.
interface mem_master_if #(
    parameter int AW = 32
) ();
    // CPU pipeline side
    logic          cpu_re;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [AW-1:0] cpu_wd;
    logic [AW-1:0] cpu_rd;
    logic          cpu_stall;
    logic          cpu_err;
    // Word memory side
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_a;
    logic [AW-1:0] mem_wd;
    logic [AW-1:0] mem_rd;
    logic          mem_ack;

    modport master (
        input  cpu_re, cpu_we, cpu_addr, cpu_wd, mem_rd, mem_ack,
        output cpu_rd, cpu_stall, cpu_err, mem_req, mem_we, mem_a, mem_wd
    );

    modport slave (
        output cpu_re, cpu_we, cpu_addr, cpu_wd, mem_rd, mem_ack,
        input  cpu_rd, cpu_stall, cpu_err, mem_req, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/mem_master.sv
// mem_master: turns single pipeline load/store requests into word-memory
// transactions. It rejects misaligned or conflicting requests without
// touching memory, and it aborts a transaction after TIMEOUT BUSY cycles
// without an ack. Each access ends with exactly one DONE cycle, where the
// stall is released and the error pulse is reported.
module mem_master #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    mem_master_if.master bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_we;
    logic [AW-1:0] r_a;
    logic [AW-1:0] r_wd;
    logic [AW-1:0] r_rd;

    logic w_req;
    logic w_legal;
    logic w_last;
    logic w_stall;
    logic w_mem_req;
    logic w_mem_we;
    logic w_cpu_err;

    // A request is legal only when it is exactly one of load/store and word aligned.
    always_comb begin
        w_req   = bus.cpu_re | bus.cpu_we;
        w_legal = (bus.cpu_re ^ bus.cpu_we) && (bus.cpu_addr[1:0] == 2'b00);
        w_last  = (r_cnt == CW'(TIMEOUT - 1));
    end

    // FSM, transaction latch, timeout counter and load-data capture.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= {CW{1'b0}};
            r_err   <= 1'b0;
            r_we    <= 1'b0;
            r_a     <= {AW{1'b0}};
            r_wd    <= {AW{1'b0}};
            r_rd    <= {AW{1'b0}};
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        if (w_legal) begin
                            r_state <= S_BUSY;
                            r_a     <= bus.cpu_addr;
                            r_wd    <= bus.cpu_wd;
                            r_we    <= bus.cpu_we;
                            r_cnt   <= {CW{1'b0}};
                            r_err   <= 1'b0;
                        end else begin
                            // Rejected request: no memory cycle, straight to DONE.
                            r_state <= S_DONE;
                            r_err   <= 1'b1;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_BUSY: begin
                    if (bus.mem_ack) begin
                        if (!r_we) begin
                            r_rd <= bus.mem_rd;
                        end else begin
                            r_rd <= r_rd;
                        end
                        r_state <= S_DONE;
                        r_err   <= 1'b0;
                    end else if (w_last) begin
                        // TIMEOUT-th BUSY cycle ended without ack: abort.
                        r_state <= S_DONE;
                        r_err   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    // Requests seen here are picked up again in the next IDLE cycle.
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_err   <= 1'b0;
                end
            endcase
        end
    end

    // Handshake outputs derived from the state register; IDLE stall follows the request directly.
    always_comb begin
        w_stall   = 1'b0;
        w_mem_req = 1'b0;
        w_mem_we  = 1'b0;
        w_cpu_err = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_stall = w_req;
            end
            S_BUSY: begin
                w_stall   = 1'b1;
                w_mem_req = 1'b1;
                w_mem_we  = r_we;
            end
            S_DONE: begin
                w_cpu_err = r_err;
            end
            default: begin
                w_stall = 1'b0;
            end
        endcase
    end

    assign bus.cpu_stall = w_stall;
    assign bus.cpu_err   = w_cpu_err;
    assign bus.mem_req   = w_mem_req;
    assign bus.mem_we    = w_mem_we;
    assign bus.mem_a     = r_a;
    assign bus.mem_wd    = r_wd;
    assign bus.cpu_rd    = r_rd;

endmodule

// File: tb/tb_mem_master.sv
// tb_mem_master: directed vectors with hand-computed expectations for mem_master.
module tb_mem_master;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    mem_master_if #(.AW(32)) bus ();

    mem_master #(.TIMEOUT(16), .AW(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one clock; sample point is 1ns after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Safety net against a hung simulation.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        n_checks = 0;
        n_errors = 0;
        reset_n      = 1'b0;
        bus.cpu_re   = 1'b0;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 32'h0;
        bus.cpu_wd   = 32'h0;
        bus.mem_rd   = 32'h0;
        bus.mem_ack  = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        // Reset state
        check_val("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("rst_stall",   {31'd0, bus.cpu_stall}, 32'd0);
        check_val("rst_err",     {31'd0, bus.cpu_err}, 32'd0);
        check_val("rst_cpu_rd",  bus.cpu_rd, 32'h0);
        check_val("rst_mem_a",   bus.mem_a, 32'h0);

        // Load 0x40, ack in first BUSY cycle
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h40;
        #1;
        check_val("ld_idle_stall", {31'd0, bus.cpu_stall}, 32'd1);
        check_val("ld_idle_req",   {31'd0, bus.mem_req}, 32'd0);
        step();
        check_val("ld_busy_req",  {31'd0, bus.mem_req}, 32'd1);
        check_val("ld_busy_a",    bus.mem_a, 32'h40);
        check_val("ld_busy_we",   {31'd0, bus.mem_we}, 32'd0);
        check_val("ld_busy_stall",{31'd0, bus.cpu_stall}, 32'd1);
        bus.mem_ack = 1'b1; bus.mem_rd = 32'hDEADBEEF;
        step();
        bus.mem_ack = 1'b0;
        check_val("ld_done_rd",    bus.cpu_rd, 32'hDEADBEEF);
        check_val("ld_done_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("ld_done_err",   {31'd0, bus.cpu_err}, 32'd0);
        check_val("ld_done_req",   {31'd0, bus.mem_req}, 32'd0);
        bus.cpu_re = 1'b0;
        step();

        // Store 0x8, ack in third BUSY cycle
        bus.cpu_we = 1'b1; bus.cpu_addr = 32'h8; bus.cpu_wd = 32'h12345678;
        bus.mem_rd = 32'h55555555;
        step();
        for (int i = 0; i < 3; i++) begin
            check_val("st_busy_req", {31'd0, bus.mem_req}, 32'd1);
            check_val("st_busy_we",  {31'd0, bus.mem_we}, 32'd1);
            check_val("st_busy_wd",  bus.mem_wd, 32'h12345678);
            check_val("st_busy_a",   bus.mem_a, 32'h8);
            if (i == 2) bus.mem_ack = 1'b1;
            step();
        end
        bus.mem_ack = 1'b0;
        check_val("st_done_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("st_done_req",   {31'd0, bus.mem_req}, 32'd0);
        check_val("st_done_rd",    bus.cpu_rd, 32'hDEADBEEF);
        check_val("st_done_err",   {31'd0, bus.cpu_err}, 32'd0);
        bus.cpu_we = 1'b0;
        step();
        check_val("st_idle_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("st_idle_we",    {31'd0, bus.mem_we}, 32'd0);
        check_val("st_idle_wd",    bus.mem_wd, 32'h12345678);

        // Misaligned load 0x6
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h6;
        #1;
        check_val("mis_idle_req", {31'd0, bus.mem_req}, 32'd0);
        step();
        check_val("mis_done_err",   {31'd0, bus.cpu_err}, 32'd1);
        check_val("mis_done_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("mis_done_req",   {31'd0, bus.mem_req}, 32'd0);
        bus.cpu_re = 1'b0;
        step();
        check_val("mis_idle_err", {31'd0, bus.cpu_err}, 32'd0);

        // Conflicting re & we
        bus.cpu_re = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'h10;
        step();
        check_val("both_done_err", {31'd0, bus.cpu_err}, 32'd1);
        check_val("both_done_req", {31'd0, bus.mem_req}, 32'd0);
        check_val("both_done_a",   bus.mem_a, 32'h8);
        bus.cpu_re = 1'b0; bus.cpu_we = 1'b0;
        step();

        // Timeout: ack never arrives
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h20; bus.mem_rd = 32'hAAAAAAAA;
        step();
        n = 0;
        while (bus.mem_req === 1'b1 && n < 40) begin
            n++;
            step();
        end
        check_val("to_req_cycles", n, 32'd16);
        check_val("to_done_err",   {31'd0, bus.cpu_err}, 32'd1);
        check_val("to_done_stall", {31'd0, bus.cpu_stall}, 32'd0);
        bus.cpu_re = 1'b0; bus.mem_ack = 1'b1;
        step();
        check_val("to_late_rd",  bus.cpu_rd, 32'hDEADBEEF);
        check_val("to_late_err", {31'd0, bus.cpu_err}, 32'd0);
        step();
        check_val("to_idle_req",   {31'd0, bus.mem_req}, 32'd0);
        check_val("to_idle_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("to_idle_rd",    bus.cpu_rd, 32'hDEADBEEF);
        bus.mem_ack = 1'b0;
        step();

        // Reset during second BUSY cycle
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h44;
        step();
        step();
        check_val("rb_busy_req", {31'd0, bus.mem_req}, 32'd1);
        #2;
        reset_n = 1'b0; bus.cpu_re = 1'b0;
        #1;
        check_val("rb_now_req", {31'd0, bus.mem_req}, 32'd0);
        step();
        reset_n = 1'b1;
        step();
        check_val("rb_rel_req",   {31'd0, bus.mem_req}, 32'd0);
        check_val("rb_rel_we",    {31'd0, bus.mem_we}, 32'd0);
        check_val("rb_rel_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("rb_rel_err",   {31'd0, bus.cpu_err}, 32'd0);
        check_val("rb_rel_rd",    bus.cpu_rd, 32'h0);
        check_val("rb_rel_a",     bus.mem_a, 32'h0);
        check_val("rb_rel_wd",    bus.mem_wd, 32'h0);

        // Fresh load after reset
        bus.cpu_re = 1'b1; bus.cpu_addr = 32'h44;
        step();
        check_val("rb_ld_req", {31'd0, bus.mem_req}, 32'd1);
        check_val("rb_ld_a",   bus.mem_a, 32'h44);
        bus.mem_ack = 1'b1; bus.mem_rd = 32'hCAFEF00D;
        step();
        bus.mem_ack = 1'b0; bus.cpu_re = 1'b0;
        check_val("rb_ld_rd",    bus.cpu_rd, 32'hCAFEF00D);
        check_val("rb_ld_stall", {31'd0, bus.cpu_stall}, 32'd0);
        check_val("rb_ld_err",   {31'd0, bus.cpu_err}, 32'd0);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum BUSY cycles awaiting mem_ack before abort.
REQ-002 SHALL have parameter AW, default 32: address and data width.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port cpu_re, input, 1: pipeline load request, held until cpu_stall is low.
REQ-006 SHALL have port cpu_we, input, 1: pipeline store request, held until cpu_stall is low.
REQ-007 SHALL have port cpu_addr, input, AW: byte address.
REQ-008 SHALL have port cpu_wd, input, AW: store data.
REQ-009 SHALL have port cpu_rd, output, AW: load data, registered.
REQ-010 SHALL have port cpu_stall, output, 1: freeze pipeline.
REQ-011 SHALL have port cpu_err, output, 1: one-cycle access-fault pulse.
REQ-012 SHALL have port mem_req, output, 1: transaction request to the word memory.
REQ-013 SHALL have port mem_we, output, 1: write qualifier for mem_req.
REQ-014 SHALL have port mem_a, output, AW: word-aligned byte address (bits[1:0] = 0).
REQ-015 SHALL have port mem_wd, output, AW: write data.
REQ-016 SHALL have port mem_rd, input, AW: read data, valid when mem_ack is high.
REQ-017 SHALL have port mem_ack, input, 1: memory completion, one or more cycles.

Function
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE, encoded in a register.
REQ-019 In IDLE, cpu_stall SHALL equal (cpu_re | cpu_we), combinationally.
REQ-020 In IDLE, a legal request (exactly one of re/we, cpu_addr[1:0]=0) SHALL latch addr/wd/we at the edge and move to BUSY.
REQ-021 In IDLE, an illegal request (re&we both high, or addr[1:0]!=0) SHALL issue no memory transaction and move to DONE with the error flag set.
REQ-022 In BUSY: mem_req=1, mem_a/mem_wd/mem_we stable at the latched values, cpu_stall=1.
REQ-023 In BUSY, mem_ack sampled high SHALL capture mem_rd into cpu_rd (loads only; stores leave cpu_rd unchanged) and move to DONE.
REQ-024 BUSY SHALL count cycles; if the TIMEOUT-th BUSY cycle ends without mem_ack, the block SHALL move to DONE with the error flag set and leave cpu_rd unchanged.
REQ-025 In DONE: cpu_stall=0 and mem_req=0 for exactly one cycle, cpu_err = error flag; next state IDLE unconditionally.
REQ-026 Requests presented during DONE SHALL be ignored; they are treated as new requests in the following IDLE cycle.
REQ-027 mem_ack outside BUSY SHALL be ignored (late or spurious acks have no effect).
REQ-028 Outside BUSY, mem_req and mem_we SHALL be 0; mem_a and mem_wd hold their last values.
REQ-029 Latency: request in IDLE at cycle 0; mem_req high from cycle 1; ack in cycle k (k>=1) gives DONE and valid cpu_rd in cycle k+1; minimum total stall 2 cycles.
REQ-030 The cycle counter SHALL clear on every entry to BUSY.

Reset
REQ-031 reset_n low SHALL immediately force state IDLE, mem_req=0, mem_we=0, cpu_err=0, error flag=0, counter=0, cpu_rd=0, mem_a=0, mem_wd=0.
REQ-032 A reset asserted in BUSY SHALL abort the transaction with no DONE cycle; after release the block SHALL be in IDLE.

Verification
REQ-033 Load addr 0x40, ack in cycle 1 with mem_rd=0xDEADBEEF -> mem_a=0x40, mem_we=0; cycle 2 DONE, cpu_rd=0xDEADBEEF, stall low, err 0.
REQ-034 Store addr 0x8 with wd 0x12345678, ack after 3 BUSY cycles -> mem_we=1 and mem_wd stable for those 3 cycles; then one DONE cycle; cpu_rd unchanged.
REQ-035 Load addr 0x6 -> no mem_req; next cycle cpu_err=1 and stall=0; re&we both high -> same outcome.
REQ-036 Load with mem_ack held low -> mem_req high for exactly 16 cycles, then cpu_err=1 pulse; a late ack in DONE or IDLE is ignored.
REQ-037 reset_n low during BUSY cycle 2 -> mem_req=0 immediately; after release, IDLE with all outputs 0; a new load then completes normally.
